// File: rtl/y86_memory_stage_pkg.sv
// Shared Y86 encodings, M-stage FSM states and pipeline-register layouts
// for the memory stage and its data-memory controller.
package y86_memory_stage_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RMMOVL = 4'h4;
    localparam logic [3:0] I_MRMOVL = 4'h5;
    localparam logic [3:0] I_OPL    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHL  = 4'hA;
    localparam logic [3:0] I_POPL   = 4'hB;

    localparam logic [3:0] R_NONE = 4'hF;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic {
        MS_IDLE = 1'b0,
        MS_REQ  = 1'b1
    } mstate_e;

    typedef struct packed {
        logic        valid;
        logic [3:0]  icode;
        logic [2:0]  stat;
        logic        cnd;
        logic [31:0] val_e;
        logic [31:0] val_a;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
    } mreg_t;

    typedef struct packed {
        logic        valid;
        logic [3:0]  icode;
        logic [2:0]  stat;
        logic        cnd;
        logic [31:0] val_e;
        logic [31:0] val_m;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
    } wreg_t;

    typedef struct packed {
        logic        access;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_op_t;

    localparam mreg_t M_BUBBLE = '{valid: 1'b0, icode: I_NOP, stat: STAT_AOK, cnd: 1'b0,
                                   val_e: 32'h0, val_a: 32'h0, dst_e: R_NONE, dst_m: R_NONE};

    localparam wreg_t W_RESET = '{valid: 1'b0, icode: I_NOP, stat: STAT_AOK, cnd: 1'b0,
                                  val_e: 32'h0, val_m: 32'h0, dst_e: R_NONE, dst_m: R_NONE};

    // Only healthy, valid instructions touch memory; everything else passes straight through.
    function automatic mem_op_t decode_mem_op(input logic        valid,
                                              input logic [3:0]  icode,
                                              input logic [2:0]  stat,
                                              input logic [31:0] val_e,
                                              input logic [31:0] val_a);
        mem_op_t op;
        op = '{access: 1'b0, we: 1'b0, addr: 32'h0, wdata: 32'h0};
        if (valid && stat == STAT_AOK) begin
            case (icode)
                I_RMMOVL, I_PUSHL, I_CALL: op = '{access: 1'b1, we: 1'b1, addr: val_e, wdata: val_a};
                I_MRMOVL:                  op = '{access: 1'b1, we: 1'b0, addr: val_e, wdata: 32'h0};
                I_POPL, I_RET:             op = '{access: 1'b1, we: 1'b0, addr: val_a, wdata: 32'h0};
                default:                   op = '{access: 1'b0, we: 1'b0, addr: 32'h0, wdata: 32'h0};
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/y86_memory_stage_if.sv
// Request/acknowledge data-memory port between the M stage (master) and memory (slave).
interface y86_memory_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        dmem_err;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata, dmem_err
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata, dmem_err
    );
endinterface

// File: rtl/y86_dmem_ctrl.sv
// Data-memory controller for the M stage: IDLE/REQ FSM, timeout counter and
// registered dmem_* drive; reports completion, error and read data to the stage.
module y86_dmem_ctrl
    import y86_memory_stage_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                start_we,
    input  logic [31:0]         start_addr,
    input  logic [31:0]         start_wdata,
    output logic                busy,
    output logic                done,
    output logic                done_err,
    output logic [31:0]         done_val_m,
    y86_memory_stage_if.master  dmem
);

    mstate_e           state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              timeout;

    assign timeout = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign busy    = (state_q == MS_REQ);

    always_comb begin
        // NOTE: every output of this block gets its hold/idle value first, so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        done       = 1'b0;
        done_err   = 1'b0;
        done_val_m = 32'h0;
        case (state_q)
            MS_IDLE: begin
                if (start) begin
                    state_d = MS_REQ;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    we_d    = start_we;
                    addr_d  = start_addr;
                    wdata_d = start_wdata;
                end
            end
            MS_REQ: begin
                // An ack on the timeout edge still completes the access normally.
                if (dmem.dmem_ack || timeout) begin
                    done       = 1'b1;
                    done_err   = dmem.dmem_ack ? dmem.dmem_err : 1'b1;
                    done_val_m = (dmem.dmem_ack && !we_q) ? dmem.dmem_rdata : 32'h0;
                    state_d    = MS_IDLE;
                    cnt_d      = '0;
                    req_d      = 1'b0;
                    we_d       = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = MS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            state_q <= MS_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;

endmodule

// File: rtl/y86_memory_stage.sv
// Pipelined Y86 memory stage: E->M register, data-memory access via y86_dmem_ctrl,
// registered M->W bundle. Optional macro MEM_ALIGN_CHK_EN faults misaligned accesses.
module y86_memory_stage
    import y86_memory_stage_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                Min_valid,
    input  logic [3:0]          Min_icode,
    input  logic [2:0]          Min_stat,
    input  logic                Min_Cnd,
    input  logic [31:0]         Min_valE,
    input  logic [31:0]         Min_valA,
    input  logic [3:0]          Min_dstE,
    input  logic [3:0]          Min_dstM,
    output logic                m_stall,
    y86_memory_stage_if.master  dmem,
    output logic                Win_valid,
    output logic [3:0]          Win_icode,
    output logic [2:0]          Win_stat,
    output logic                Win_Cnd,
    output logic [31:0]         Win_valE,
    output logic [31:0]         Win_valM,
    output logic [3:0]          Win_dstE,
    output logic [3:0]          Win_dstM
);

    mreg_t       m_q, m_d;
    wreg_t       w_q, w_d;
    mem_op_t     op;
    logic        misaligned;
    logic        start;
    logic        busy;
    logic        done;
    logic        done_err;
    logic [31:0] done_val_m;

    assign op = decode_mem_op(m_q.valid, m_q.icode, m_q.stat, m_q.val_e, m_q.val_a);

`ifdef MEM_ALIGN_CHK_EN
    assign misaligned = op.access && (op.addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign start   = !busy && op.access && !misaligned;
    assign m_stall = busy;

    y86_dmem_ctrl #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_dmem_ctrl (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .start_we    (op.we),
        .start_addr  (op.addr),
        .start_wdata (op.wdata),
        .busy        (busy),
        .done        (done),
        .done_err    (done_err),
        .done_val_m  (done_val_m),
        .dmem        (dmem)
    );

    always_comb begin
        m_d = m_q;
        if (!m_stall) begin
            m_d = Min_valid ? '{valid: 1'b1, icode: Min_icode, stat: Min_stat, cnd: Min_Cnd,
                                val_e: Min_valE, val_a: Min_valA, dst_e: Min_dstE, dst_m: Min_dstM}
                            : M_BUBBLE;
        end

        // While an access is in flight W already holds its fields; only valid/valM/stat finalise.
        w_d       = w_q;
        w_d.valid = 1'b0;
        if (busy) begin
            if (done) begin
                w_d.valid = 1'b1;
                w_d.val_m = done_val_m;
                if (done_err) w_d.stat = STAT_ADR;
            end
        end else begin
            w_d = '{valid: m_q.valid && !start, icode: m_q.icode, stat: m_q.stat, cnd: m_q.cnd,
                    val_e: m_q.val_e, val_m: 32'h0, dst_e: m_q.dst_e, dst_m: m_q.dst_m};
            if (misaligned) w_d.stat = STAT_ADR;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q <= M_BUBBLE;
            w_q <= W_RESET;
        end else begin
            m_q <= m_d;
            w_q <= w_d;
        end
    end

    assign Win_valid = w_q.valid;
    assign Win_icode = w_q.icode;
    assign Win_stat  = w_q.stat;
    assign Win_Cnd   = w_q.cnd;
    assign Win_valE  = w_q.val_e;
    assign Win_valM  = w_q.val_m;
    assign Win_dstE  = w_q.dst_e;
    assign Win_dstM  = w_q.dst_m;

endmodule

// File: tb/tb_y86_memory_stage.sv
// Scoreboard bench for y86_memory_stage: directed instructions, a scripted memory
// responder that checks each bus request, and a W-side monitor popping expected bundles.
module tb_y86_memory_stage;
    import y86_memory_stage_pkg::*;

    typedef struct {
        logic [3:0]  icode;
        logic [2:0]  stat;
        logic        cnd;
        logic [31:0] val_e;
        logic [31:0] val_m;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
        int          arr;
    } wexp_t;

    // Field order: we, addr, wdata, ack_after (0 = never), rdata, err, held (0 = unchecked).
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ack_after;
        logic [31:0] rdata;
        logic        err;
        int          held;
    } bexp_t;

    localparam bexp_t NO_BUS = '{1'b0, 32'h0, 32'h0, 0, 32'h0, 1'b0, 0};

    logic        clk;
    logic        reset;
    logic        min_valid;
    logic [3:0]  min_icode;
    logic [2:0]  min_stat;
    logic        min_cnd;
    logic [31:0] min_vale;
    logic [31:0] min_vala;
    logic [3:0]  min_dste;
    logic [3:0]  min_dstm;
    logic        m_stall;
    logic        win_valid;
    logic [3:0]  win_icode;
    logic [2:0]  win_stat;
    logic        win_cnd;
    logic [31:0] win_vale;
    logic [31:0] win_valm;
    logic [3:0]  win_dste;
    logic [3:0]  win_dstm;

    y86_memory_stage_if dmem_if ();

    y86_memory_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .Min_valid (min_valid),
        .Min_icode (min_icode),
        .Min_stat  (min_stat),
        .Min_Cnd   (min_cnd),
        .Min_valE  (min_vale),
        .Min_valA  (min_vala),
        .Min_dstE  (min_dste),
        .Min_dstM  (min_dstm),
        .m_stall   (m_stall),
        .dmem      (dmem_if),
        .Win_valid (win_valid),
        .Win_icode (win_icode),
        .Win_stat  (win_stat),
        .Win_Cnd   (win_cnd),
        .Win_valE  (win_vale),
        .Win_valM  (win_valm),
        .Win_dstE  (win_dste),
        .Win_dstM  (win_dstm)
    );

    int    vectors = 0;
    int    miscompares = 0;
    int    cyc = 0;
    int    stray_req = 0;
    int    stray_done = 0;
    wexp_t wq[$];
    bexp_t bq[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got t=%0t required earlier end", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h required 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_bubble();
        min_valid = 1'b0;
        min_icode = I_NOP;
        min_stat  = STAT_AOK;
        min_cnd   = 1'b0;
        min_vale  = 32'h0;
        min_vala  = 32'h0;
        min_dste  = R_NONE;
        min_dstm  = R_NONE;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        drive_bubble();
        repeat (n) @(negedge clk);
    endtask

    // lat < 0: no W bundle expected (access abandoned by reset).
    task automatic issue(input logic [3:0] icode, input logic [2:0] st, input logic cnd,
                         input logic [31:0] vale, input logic [31:0] vala,
                         input logic [3:0] dste, input logic [3:0] dstm,
                         input logic [2:0] exp_stat, input logic [31:0] exp_valm,
                         input int lat, input logic has_bus, input bexp_t b);
        logic  stalled;
        logic  cap;
        wexp_t e;
        @(negedge clk);
        min_valid = 1'b1;
        min_icode = icode;
        min_stat  = st;
        min_cnd   = cnd;
        min_vale  = vale;
        min_vala  = vala;
        min_dste  = dste;
        min_dstm  = dstm;
        cap = 1'b0;
        for (int n = 0; n < 64 && !cap; n++) begin
            stalled = m_stall;
            @(posedge clk);
            if (!stalled) cap = 1'b1;
            else @(negedge clk);
        end
        check("capture", {31'h0, cap}, 32'h1);
        #1;
        if (lat >= 0) begin
            e = '{icode, exp_stat, cnd, vale, exp_valm, dste, dstm, cyc + lat};
            wq.push_back(e);
        end
        if (has_bus) bq.push_back(b);
    endtask

    // Memory responder: checks each new request against the script and acks on cue.
    initial begin
        bexp_t cur;
        logic  active;
        int    held;
        cur    = NO_BUS;
        active = 1'b0;
        held   = 0;
        dmem_if.dmem_ack   = 1'b0;
        dmem_if.dmem_rdata = 32'h0;
        dmem_if.dmem_err   = 1'b0;
        forever begin
            @(negedge clk);
            dmem_if.dmem_ack   = 1'b0;
            dmem_if.dmem_rdata = 32'h0;
            dmem_if.dmem_err   = 1'b0;
            check("m_stall_vs_req", {31'h0, m_stall}, {31'h0, dmem_if.dmem_req});
            if (dmem_if.dmem_req) begin
                if (!active) begin
                    active = 1'b1;
                    held   = 0;
                    if (bq.size() == 0) begin
                        check("bus_unexpected_req", 32'h1, 32'h0);
                        cur = NO_BUS;
                    end else begin
                        cur = bq.pop_front();
                        check("bus_we", {31'h0, dmem_if.dmem_we}, {31'h0, cur.we});
                        check("bus_addr", dmem_if.dmem_addr, cur.addr);
                        check("bus_wdata", dmem_if.dmem_wdata, cur.wdata);
                    end
                end
                held++;
                if (cur.ack_after != 0 && held == cur.ack_after) begin
                    dmem_if.dmem_ack   = 1'b1;
                    dmem_if.dmem_rdata = cur.rdata;
                    dmem_if.dmem_err   = cur.err;
                end
            end else begin
                if (active) begin
                    active = 1'b0;
                    if (cur.held != 0) check("req_cycles", 32'(held), 32'(cur.held));
                end
                if (stray_done != stray_req) begin
                    stray_done         = stray_req;
                    dmem_if.dmem_ack   = 1'b1;
                    dmem_if.dmem_rdata = 32'h5555AAAA;
                end
            end
        end
    end

    // W-side monitor.
    always @(negedge clk) begin
        wexp_t e;
        if (reset && win_valid) begin
            if (wq.size() == 0) begin
                check("w_unexpected_valid", 32'h1, 32'h0);
            end else begin
                e = wq.pop_front();
                check("w_icode", {28'h0, win_icode}, {28'h0, e.icode});
                check("w_stat",  {29'h0, win_stat},  {29'h0, e.stat});
                check("w_cnd",   {31'h0, win_cnd},   {31'h0, e.cnd});
                check("w_valE",  win_vale, e.val_e);
                check("w_valM",  win_valm, e.val_m);
                check("w_dstE",  {28'h0, win_dste},  {28'h0, e.dst_e});
                check("w_dstM",  {28'h0, win_dstm},  {28'h0, e.dst_m});
                check("w_latency", 32'(cyc), 32'(e.arr));
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_req"},    {31'h0, dmem_if.dmem_req}, 32'h0);
        check({tag, "_we"},     {31'h0, dmem_if.dmem_we},  32'h0);
        check({tag, "_addr"},   dmem_if.dmem_addr,  32'h0);
        check({tag, "_wdata"},  dmem_if.dmem_wdata, 32'h0);
        check({tag, "_stall"},  {31'h0, m_stall},   32'h0);
        check({tag, "_wvalid"}, {31'h0, win_valid}, 32'h0);
        check({tag, "_wicode"}, {28'h0, win_icode}, 32'h1);
        check({tag, "_wstat"},  {29'h0, win_stat},  32'h1);
        check({tag, "_wdstE"},  {28'h0, win_dste},  32'hF);
        check({tag, "_wdstM"},  {28'h0, win_dstm},  32'hF);
        check({tag, "_wvalE"},  win_vale, 32'h0);
        check({tag, "_wvalM"},  win_valm, 32'h0);
    endtask

    initial begin
        reset = 1'b0;
        drive_bubble();
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        reset = 1'b1;

        // OPL: no access, one edge to W
        issue(I_OPL, STAT_AOK, 1'b0, 32'h5, 32'h0, 4'h2, R_NONE, STAT_AOK, 32'h0, 1, 1'b0, NO_BUS);
        idle(2);
        // MRMOVL: ack on 3rd request cycle
        issue(I_MRMOVL, STAT_AOK, 1'b0, 32'h100, 32'h77, R_NONE, 4'h3, STAT_AOK, 32'hDEADBEEF, 4, 1'b1,
              '{1'b0, 32'h100, 32'h0, 3, 32'hDEADBEEF, 1'b0, 3});
        idle(6);
        // PUSHL: write, ack next cycle, read data must not leak into valM
        issue(I_PUSHL, STAT_AOK, 1'b0, 32'h1FC, 32'h42, 4'h4, R_NONE, STAT_AOK, 32'h0, 2, 1'b1,
              '{1'b1, 32'h1FC, 32'h42, 1, 32'h0BADF00D, 1'b0, 1});
        idle(4);
        // POPL: no ack -> timeout after 16 request cycles
        issue(I_POPL, STAT_AOK, 1'b0, 32'h204, 32'h200, 4'h4, 4'h5, STAT_ADR, 32'h0, 17, 1'b1,
              '{1'b0, 32'h200, 32'h0, 0, 32'h0, 1'b0, 16});
        idle(20);
        // Non-AOK upstream: no access, status passes unchanged
        issue(I_RMMOVL, STAT_INS, 1'b0, 32'h80, 32'h9, R_NONE, R_NONE, STAT_INS, 32'h0, 1, 1'b0, NO_BUS);
        idle(2);
        issue(I_HALT, STAT_HLT, 1'b0, 32'h0, 32'h0, R_NONE, R_NONE, STAT_HLT, 32'h0, 1, 1'b0, NO_BUS);
        idle(2);
        // CALL: write acked with bus error
        issue(I_CALL, STAT_AOK, 1'b0, 32'h1F8, 32'h123, 4'h4, R_NONE, STAT_ADR, 32'h0, 3, 1'b1,
              '{1'b1, 32'h1F8, 32'h123, 2, 32'h0, 1'b1, 2});
        idle(5);
        // RET: read from valA
        issue(I_RET, STAT_AOK, 1'b0, 32'h304, 32'h300, 4'h4, R_NONE, STAT_AOK, 32'h40, 2, 1'b1,
              '{1'b0, 32'h300, 32'h0, 1, 32'h40, 1'b0, 1});
        idle(4);
        // Back-to-back: OPL rides behind the access, JXX waits out the stall
        issue(I_MRMOVL, STAT_AOK, 1'b0, 32'h10, 32'h0, R_NONE, 4'h6, STAT_AOK, 32'h11111111, 3, 1'b1,
              '{1'b0, 32'h10, 32'h0, 2, 32'h11111111, 1'b0, 2});
        issue(I_OPL, STAT_AOK, 1'b1, 32'h9, 32'h0, 4'h1, R_NONE, STAT_AOK, 32'h0, 3, 1'b0, NO_BUS);
        issue(I_JXX, STAT_AOK, 1'b1, 32'h50, 32'h60, R_NONE, R_NONE, STAT_AOK, 32'h0, 1, 1'b0, NO_BUS);
        idle(4);
        // ack while idle must be ignored
        stray_req++;
        idle(4);
        check("idle_ack_req", {31'h0, dmem_if.dmem_req}, 32'h0);
        // Misaligned address
`ifdef MEM_ALIGN_CHK_EN
        issue(I_MRMOVL, STAT_AOK, 1'b0, 32'h102, 32'h0, R_NONE, 4'h3, STAT_ADR, 32'h0, 1, 1'b0, NO_BUS);
`else
        issue(I_MRMOVL, STAT_AOK, 1'b0, 32'h102, 32'h0, R_NONE, 4'h3, STAT_AOK, 32'h0000CAFE, 2, 1'b1,
              '{1'b0, 32'h102, 32'h0, 1, 32'h0000CAFE, 1'b0, 1});
`endif
        idle(4);
        // Reset in the middle of an access abandons it
        issue(I_MRMOVL, STAT_AOK, 1'b0, 32'h400, 32'h0, R_NONE, 4'h3, STAT_AOK, 32'h0, -1, 1'b1,
              '{1'b0, 32'h400, 32'h0, 0, 32'h0, 1'b0, 0});
        @(negedge clk);
        drive_bubble();
        repeat (2) @(negedge clk);
        check("pre_reset_req", {31'h0, dmem_if.dmem_req}, 32'h1);
        #2 reset = 1'b0;
        #1 check_reset_state("midreset");
        @(negedge clk);
        reset = 1'b1;
        // Pipeline works again after reset
        issue(I_OPL, STAT_AOK, 1'b1, 32'hA5A5, 32'h0, 4'h7, R_NONE, STAT_AOK, 32'h0, 1, 1'b0, NO_BUS);
        idle(2);

        for (int n = 0; n < 100 && (wq.size() != 0 || bq.size() != 0 || dmem_if.dmem_req); n++)
            @(negedge clk);
        @(negedge clk);
        check("w_queue_drained", 32'(wq.size()), 32'h0);
        check("bus_queue_drained", 32'(bq.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
